// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, ExcCode values, field bit positions.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package cp0_pkg;

    // CP0 register numbers used by mtc0/mfc0
    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    // ExcCode values
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Field positions inside SR and Cause
    localparam int SR_IM_LSB     = 10;
    localparam int SR_EXL_BIT    = 1;
    localparam int SR_IE_BIT     = 0;
    localparam int CAUSE_BD_BIT  = 31;
    localparam int CAUSE_IP_LSB  = 10;
    localparam int CAUSE_EXC_LSB = 2;

    // EPC always holds a word-aligned address
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_req_gen.sv
// CP0 request generator: interrupt/exception request and the ExcCode to record.
// Latency: purely combinational, same cycle.
// Backpressure: none; EXL=1 masks every new request so nested events are dropped.
import cp0_pkg::*;

module cp0_req_gen (
    input  logic       exl_i,
    input  logic       ie_i,
    input  logic [5:0] im_i,
    input  logic [5:0] hw_int_i,
    input  logic [4:0] m_exc_code_i,
    output logic       int_req_o,
    output logic       exc_req_o,
    output logic       req_o,
    output logic [4:0] exc_code_o
);

    // Interrupt wins over a simultaneous exception and is logged as ExcCode 0
    always_comb begin
        int_req_o  = ie_i & ~exl_i & (|(im_i & hw_int_i));
        exc_req_o  = ~exl_i & (m_exc_code_i != EXC_INT);
        req_o      = int_req_o | exc_req_o;
        exc_code_o = int_req_o ? EXC_INT : m_exc_code_i;
    end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: owns SR, Cause, EPC, PRId; flush request and eret return.
// Latency: req/exl_clr/epc_out/cp0_rdata combinational; state visible one cycle after update.
// Backpressure: none. Optional macro CP0_EPC_BYPASS_EN forwards an mtc0 EPC to epc_out on eret.
import cp0_pkg::*;

module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL   = 32'h2022_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic [4:0]  m_exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic        exl_clr,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    logic [5:0]  sr_im_q,     sr_im_d;
    logic        sr_exl_q,    sr_exl_d;
    logic        sr_ie_q,     sr_ie_d;
    logic        cause_bd_q,  cause_bd_d;
    logic [5:0]  cause_ip_q,  cause_ip_d;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q,       epc_d;

    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code_sel;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    cp0_req_gen u_req_gen (
        .exl_i        (sr_exl_q),
        .ie_i         (sr_ie_q),
        .im_i         (sr_im_q),
        .hw_int_i     (hw_int),
        .m_exc_code_i (m_exc_code),
        .int_req_o    (int_req),
        .exc_req_o    (exc_req),
        .req_o        (req),
        .exc_code_o   (exc_code_sel)
    );

    assign exl_clr    = eret & ~req;
    assign handler_pc = HANDLER_PC;

    // Return PC; the bypass lets eret sit right behind an mtc0 EPC without a stall
`ifdef CP0_EPC_BYPASS_EN
    assign epc_out = (we && (cp0_addr == REG_EPC) && !req && eret) ? word_align(cp0_wdata) : epc_q;
`else
    assign epc_out = epc_q;
`endif

    // Assemble architectural SR/Cause images and the mfc0 read mux (no write-through)
    always_comb begin
        sr_val                                  = '0;
        sr_val[SR_IM_LSB +: 6]                  = sr_im_q;
        sr_val[SR_EXL_BIT]                      = sr_exl_q;
        sr_val[SR_IE_BIT]                       = sr_ie_q;
        cause_val                               = '0;
        cause_val[CAUSE_BD_BIT]                 = cause_bd_q;
        cause_val[CAUSE_IP_LSB +: 6]            = cause_ip_q;
        cause_val[CAUSE_EXC_LSB +: 5]           = cause_exc_q;
        case (cp0_addr)
            REG_SR:    cp0_rdata = sr_val;
            REG_CAUSE: cp0_rdata = cause_val;
            REG_EPC:   cp0_rdata = epc_q;
            REG_PRID:  cp0_rdata = PRID_VAL;
            default:   cp0_rdata = '0;
        endcase
    end

    // Next state: exception entry beats mtc0; eret clears EXL after any SR write
    always_comb begin
        sr_im_d     = sr_im_q;
        sr_exl_d    = sr_exl_q;
        sr_ie_d     = sr_ie_q;
        cause_bd_d  = cause_bd_q;
        cause_ip_d  = hw_int;
        cause_exc_d = cause_exc_q;
        epc_d       = epc_q;
        if (req) begin
            sr_exl_d    = 1'b1;
            cause_bd_d  = m_bd;
            cause_exc_d = exc_code_sel;
            epc_d       = word_align(m_bd ? (m_pc - 32'd4) : m_pc);
        end else begin
            if (we) begin
                case (cp0_addr)
                    REG_SR: begin
                        sr_im_d  = cp0_wdata[SR_IM_LSB +: 6];
                        sr_exl_d = cp0_wdata[SR_EXL_BIT];
                        sr_ie_d  = cp0_wdata[SR_IE_BIT];
                    end
                    REG_EPC: epc_d = word_align(cp0_wdata);
                    default: ;
                endcase
            end
            if (exl_clr) begin
                sr_exl_d = 1'b0;
            end
        end
    end

    // CP0 state registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_exl_q    <= 1'b0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            sr_im_q     <= sr_im_d;
            sr_exl_q    <= sr_exl_d;
            sr_ie_q     <= sr_ie_d;
            cause_bd_q  <= cause_bd_d;
            cause_ip_q  <= cause_ip_d;
            cause_exc_q <= cause_exc_d;
            epc_q       <= epc_d;
        end
    end

endmodule
